adsr_envelope: RTL and testbench
================================

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 SHALL have parameter EW, default 16, envelope level width.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port env_tick_i  input  1  one-cycle envelope update strobe; state and level change only on tick cycles.
REQ-005 SHALL have port gate_i  input  1  note held (high) or released (low).
REQ-006 SHALL have port sample_i  input  16  signed oscillator sample from the sine NCO.
REQ-007 SHALL have port attack_step_i  input  EW  level increment per tick in ATTACK.
REQ-008 SHALL have port decay_step_i  input  EW  level decrement per tick in DECAY.
REQ-009 SHALL have port sustain_lvl_i  input  EW  sustain level.
REQ-010 SHALL have port release_step_i  input  EW  level decrement per tick in RELEASE.
REQ-011 SHALL have port sample_o  output  16  signed enveloped sample.
REQ-012 SHALL have port env_o  output  EW  current envelope level, unsigned.
REQ-013 SHALL have port active_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 SHALL register gate_i every clock; gate_i high while the registered gate is low sets a sticky retrig flag, cleared on the next tick cycle.
REQ-016 On a tick, priority SHALL be: retrig -> ATTACK (level kept, legato); else gate low in ATTACK/DECAY/SUSTAIN -> RELEASE; else normal progression.
REQ-017 ATTACK: level += attack_step_i, saturating at peak (2^EW-1); on reaching peak, go to DECAY; attack_step_i=0 sets level to peak in one tick.
REQ-018 DECAY: level -= decay_step_i, floored at sustain_lvl_i; on reaching it, go to SUSTAIN; if level is already <= sustain_lvl_i, set level=sustain_lvl_i and go to SUSTAIN.
REQ-019 SUSTAIN: level = sustain_lvl_i on every tick (live tracking).
REQ-020 RELEASE: level -= release_step_i, floored at 0; on reaching 0, go to IDLE; release_step_i=0 holds the level.
REQ-021 IDLE: level held at 0; gate high without a rising edge SHALL NOT leave IDLE.
REQ-022 sample_o SHALL be bits [31:16] of signed(sample_i) * unsigned(env_o) (arithmetic shift), registered, latency 1 clock.
REQ-023 A retrig and a gate fall between the same two ticks SHALL resolve to ATTACK if gate_i is high at the tick, else RELEASE.

Reset
REQ-024 rst SHALL force: state IDLE, env_o 0, sample_o 0, active_o 0, retrig 0, registered gate 0; reset mid-note SHALL abort silently.

Configuration
REQ-025 With ADSR_VELOCITY_EN defined, SHALL add port velocity_i input 7; it is captured on the retrig; peak = {velocity, 9'h1FF}; sustain is limited to peak.
REQ-026 Without ADSR_VELOCITY_EN, there SHALL be no velocity_i and peak SHALL be 2^EW-1.

Structure
REQ-027 The state encoding, EW default and peak constant SHALL live in package synth_pkg.
REQ-028 The registered multiply SHALL be sub-module vca_mult; everything else stays in adsr_envelope.

Verification
REQ-029 Reset, then gate high; attack=0x4000, tick every cycle -> env 0x4000, 0x8000, 0xC000, 0xFFFF; DECAY on the 4th tick.
REQ-030 decay=0x1000, sustain=0x8000 -> level reaches 0x8000 after 8 ticks; SUSTAIN; change sustain to 0x6000 -> env 0x6000 on the next tick.
REQ-031 Gate low in SUSTAIN at 0x6000, release=0x2000 -> 0x4000, 0x2000, 0x0000, then IDLE with active_o=0.
REQ-032 Gate low->high->low pulse between ticks in RELEASE at 0x3000 -> next tick RELEASE (gate low wins); a pulse that leaves gate high -> ATTACK from 0x3000.
REQ-033 env=0xFFFF: sample_i 0x7FFF -> sample_o 0x7FFE; sample_i 0x8000 -> 0x8000; env=0 -> 0, all one clock later.
REQ-034 rst asserted mid-ATTACK -> next clock all outputs 0; with ADSR_VELOCITY_EN, velocity 64 -> attack peaks at 0x81FF.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared state encoding, level-width default and peak constant for the synth voice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package synth_pkg;

    localparam int ENV_W_DEF = 16;
    localparam int VEL_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    // Full-scale envelope peak for a level width of ew bits: 2^ew - 1.
    function automatic logic [63:0] peak_of(input int ew);
        return (64'd1 << ew) - 64'd1;
    endfunction

endpackage

// File: rtl/vca_mult.sv
// Voltage-controlled amplifier: signed sample scaled by unsigned envelope, top 16 bits kept.
// Latency: 1 clock (registered product).
// Backpressure: none; accepts a new sample every clock.
module vca_mult #(
    parameter int EW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [15:0]  sample_i,
    input  logic [EW-1:0]       env_i,
    output logic signed [15:0]  sample_o
);

    // Envelope is zero-extended so it multiplies as a non-negative signed value.
    logic signed [EW+16:0] samp_ext;
    logic signed [EW+16:0] env_ext;
    logic signed [EW+16:0] prod;

    assign samp_ext = (EW+17)'(sample_i);
    assign env_ext  = (EW+17)'({1'b0, env_i});
    assign prod     = samp_ext * env_ext;

    // Register the scaled sample; dropping the low EW bits is an arithmetic shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_o <= '0;
        end else begin
            sample_o <= prod[EW+15:EW];
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator driving a VCA; define ADSR_VELOCITY_EN for velocity-scaled peak.
// Latency: level/state update on env_tick_i cycles; sample_o 1 clock after sample_i/env_o.
// Backpressure: none; gate edges between ticks are held in a sticky retrig flag.
module adsr_envelope import synth_pkg::*; #(
    parameter int EW = ENV_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                env_tick_i,
    input  logic                gate_i,
    input  logic signed [15:0]  sample_i,
    input  logic [EW-1:0]       attack_step_i,
    input  logic [EW-1:0]       decay_step_i,
    input  logic [EW-1:0]       sustain_lvl_i,
    input  logic [EW-1:0]       release_step_i,
`ifdef ADSR_VELOCITY_EN
    input  logic [VEL_W-1:0]    velocity_i,
`endif
    output logic signed [15:0]  sample_o,
    output logic [EW-1:0]       env_o,
    output logic                active_o
);

    env_state_t    state_q;
    env_state_t    state_d;
    env_state_t    op;
    logic [EW-1:0] level_d;
    logic          gate_q;
    logic          retrig_q;
    logic          retrig_now;
    logic          retrig_go;
    logic [EW-1:0] peak;
    logic [EW-1:0] sus_eff;
    logic [EW:0]   att_sum;
    logic [EW:0]   dec_diff;

    // A rising gate seen on the tick cycle itself counts toward that tick.
    assign retrig_now = retrig_q | (gate_i & ~gate_q);
    // Retrigger only wins if the gate is still held when the tick arrives.
    assign retrig_go  = env_tick_i & retrig_now & gate_i;

`ifdef ADSR_VELOCITY_EN
    logic [VEL_W-1:0] vel_q;
    logic [VEL_W-1:0] vel_eff;

    assign vel_eff = retrig_go ? velocity_i : vel_q;
    assign peak    = {vel_eff, {(EW-VEL_W){1'b1}}};

    // Capture note velocity when a retrigger starts a new attack.
    always_ff @(posedge clk) begin
        if (rst) begin
            vel_q <= '1;
        end else if (retrig_go) begin
            vel_q <= velocity_i;
        end
    end
`else
    localparam logic [EW-1:0] PEAK_FULL = EW'(peak_of(EW));
    assign peak = PEAK_FULL;
`endif

    assign sus_eff  = (sustain_lvl_i > peak) ? peak : sustain_lvl_i;
    assign att_sum  = {1'b0, env_o} + {1'b0, attack_step_i};
    assign dec_diff = {1'b0, env_o} - {1'b0, decay_step_i};
    assign active_o = (state_q != ST_IDLE);

    // Next-state/level: pick the effective phase for this tick, then apply its rule.
    always_comb begin
        state_d = state_q;
        level_d = env_o;
        op      = state_q;
        if (env_tick_i) begin
            if (retrig_go) begin
                op = ST_ATTACK;
            end else if (!gate_i && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                     state_q == ST_SUSTAIN)) begin
                op = ST_RELEASE;
            end
            case (op)
                ST_ATTACK: begin
                    if (attack_step_i == '0 || att_sum >= {1'b0, peak}) begin
                        level_d = peak;
                        state_d = ST_DECAY;
                    end else begin
                        level_d = att_sum[EW-1:0];
                        state_d = ST_ATTACK;
                    end
                end
                ST_DECAY: begin
                    if (dec_diff[EW] || dec_diff[EW-1:0] <= sus_eff) begin
                        level_d = sus_eff;
                        state_d = ST_SUSTAIN;
                    end else begin
                        level_d = dec_diff[EW-1:0];
                        state_d = ST_DECAY;
                    end
                end
                ST_SUSTAIN: begin
                    level_d = sus_eff;
                    state_d = ST_SUSTAIN;
                end
                ST_RELEASE: begin
                    if (env_o <= release_step_i) begin
                        level_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        level_d = env_o - release_step_i;
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, level, gate history and sticky retrigger registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            env_o    <= '0;
            gate_q   <= 1'b0;
            retrig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            env_o    <= level_d;
            gate_q   <= gate_i;
            retrig_q <= env_tick_i ? 1'b0 : retrig_now;
        end
    end

    vca_mult #(.EW(EW)) u_vca (
        .clk      (clk),
        .rst      (rst),
        .sample_i (sample_i),
        .env_i    (env_o),
        .sample_o (sample_o)
    );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed note sequences plus randomized traffic.
// Latency: compares every output 1ns after each rising edge against a behavioural model.
// Backpressure: n/a.
module tb_adsr_envelope;

    localparam int EW = 16;
    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               env_tick_i = 1'b0;
    logic               gate_i = 1'b0;
    logic signed [15:0] sample_i = '0;
    logic [EW-1:0]      attack_step_i = '0;
    logic [EW-1:0]      decay_step_i = '0;
    logic [EW-1:0]      sustain_lvl_i = '0;
    logic [EW-1:0]      release_step_i = '0;
`ifdef ADSR_VELOCITY_EN
    logic [6:0]         velocity_i = 7'd127;
`endif
    logic signed [15:0] sample_o;
    logic [EW-1:0]      env_o;
    logic               active_o;

    always #5 clk = ~clk;

    adsr_envelope #(.EW(EW)) dut (
        .clk            (clk),
        .rst            (rst),
        .env_tick_i     (env_tick_i),
        .gate_i         (gate_i),
        .sample_i       (sample_i),
        .attack_step_i  (attack_step_i),
        .decay_step_i   (decay_step_i),
        .sustain_lvl_i  (sustain_lvl_i),
        .release_step_i (release_step_i),
`ifdef ADSR_VELOCITY_EN
        .velocity_i     (velocity_i),
`endif
        .sample_o       (sample_o),
        .env_o          (env_o),
        .active_o       (active_o)
    );

    int    n_chk = 0;
    int    n_pass = 0;
    string phase = "init";

    // Behavioural model: phase number, level as a plain integer, gate history, retrig flag.
    int                 m_st = M_IDLE;
    int                 m_lvl = 0;
    int                 m_vel = 127;
    bit                 m_gq = 1'b0;
    bit                 m_rt = 1'b0;
    logic signed [15:0] m_samp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample,
    // then step the clock and compare all outputs.
    task automatic cyc();
        int n_st, n_lvl, n_vel, pk, sus, mode, a, d, r;
        bit n_gq, n_rt, rt, go;
        logic signed [15:0] n_samp;
        longint p;
        if (rst) begin
            n_st = M_IDLE; n_lvl = 0; n_vel = 127; n_gq = 0; n_rt = 0; n_samp = '0;
        end else begin
            p      = longint'(sample_i) * longint'(m_lvl);
            n_samp = 16'(p >>> 16);
            n_gq   = gate_i;
            rt     = m_rt || (gate_i && !m_gq);
            n_rt   = rt;
            n_st   = m_st;
            n_lvl  = m_lvl;
            n_vel  = m_vel;
            if (env_tick_i) begin
                n_rt = 0;
                go   = rt && gate_i;
`ifdef ADSR_VELOCITY_EN
                if (go) n_vel = int'(velocity_i);
                pk = n_vel * 512 + 511;
`else
                pk = 65535;
`endif
                sus = int'(sustain_lvl_i);
                if (sus > pk) sus = pk;
                a = int'(attack_step_i);
                d = int'(decay_step_i);
                r = int'(release_step_i);
                mode = m_st;
                if (go) mode = M_ATT;
                else if (!gate_i && m_st >= M_ATT && m_st <= M_SUS) mode = M_REL;
                case (mode)
                    M_ATT: begin
                        n_lvl = (a == 0) ? pk : m_lvl + a;
                        if (n_lvl >= pk) begin n_lvl = pk; n_st = M_DEC; end
                        else n_st = M_ATT;
                    end
                    M_DEC: begin
                        n_lvl = m_lvl - d;
                        if (n_lvl <= sus) begin n_lvl = sus; n_st = M_SUS; end
                        else n_st = M_DEC;
                    end
                    M_SUS: begin n_lvl = sus; n_st = M_SUS; end
                    M_REL: begin
                        n_lvl = m_lvl - r;
                        if (n_lvl <= 0) begin n_lvl = 0; n_st = M_IDLE; end
                        else n_st = M_REL;
                    end
                    default: begin n_lvl = 0; n_st = M_IDLE; end
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_st = n_st; m_lvl = n_lvl; m_vel = n_vel; m_gq = n_gq; m_rt = n_rt; m_samp = n_samp;
        chk({phase, ".env"}, 32'(env_o), 32'(m_lvl));
        chk({phase, ".active"}, 32'(active_o), 32'(m_st != M_IDLE));
        chk({phase, ".sample"}, sample_o, m_samp);
    endtask

    function automatic logic [15:0] pick_step();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(1, 255));
            2:       return 16'($urandom_range(256, 16'h4000));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        phase = "reset";
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_env", 32'(env_o), 32'h0);
        chk("rst_active", 32'(active_o), 32'h0);
        chk("rst_sample", sample_o, 32'h0);

        // Attack ramp with a tick every cycle.
        rst = 1'b0;
        attack_step_i = 16'h4000; decay_step_i = 16'h1000;
        sustain_lvl_i = 16'h8000; release_step_i = 16'h2000;
        env_tick_i = 1'b1; gate_i = 1'b1; sample_i = 16'h7FFF;
        phase = "attack";
        cyc(); chk("att1", 32'(env_o), 32'h4000);
        cyc(); chk("att2", 32'(env_o), 32'h8000);
        cyc(); chk("att3", 32'(env_o), 32'hC000);
        cyc(); chk("att4", 32'(env_o), 32'hFFFF);

        // Decay to sustain; first decay cycle also shows the full-scale VCA product.
        phase = "decay";
        cyc(); chk("vca_pos", sample_o, 32'h7FFE);
        for (int i = 0; i < 7; i++) cyc();
        chk("dec8", 32'(env_o), 32'h8000);
        phase = "sustain";
        sustain_lvl_i = 16'h6000;
        cyc(); chk("sus_track", 32'(env_o), 32'h6000);

        // Release to idle.
        phase = "release";
        gate_i = 1'b0;
        cyc(); chk("rel1", 32'(env_o), 32'h4000);
        cyc(); chk("rel2", 32'(env_o), 32'h2000);
        cyc(); chk("rel3", 32'(env_o), 32'h0000);
        chk("rel_idle", 32'(active_o), 32'h0);

        // Park in RELEASE at 0x3000, then gate pulses between ticks.
        phase = "pulse";
        gate_i = 1'b1; attack_step_i = 16'h3000;
        cyc();
        gate_i = 1'b0; release_step_i = 16'h0000;
        cyc();
        env_tick_i = 1'b0;
        gate_i = 1'b1; cyc();
        gate_i = 1'b0; cyc();
        release_step_i = 16'h1000; env_tick_i = 1'b1;
        cyc(); chk("pulse_low", 32'(env_o), 32'h2000);
        env_tick_i = 1'b0; release_step_i = 16'h0000;
        gate_i = 1'b1; cyc();
        gate_i = 1'b0; cyc();
        gate_i = 1'b1; cyc();
        attack_step_i = 16'h0800; env_tick_i = 1'b1;
        cyc(); chk("pulse_high", 32'(env_o), 32'h2800);
        cyc(); chk("pulse_att", 32'(env_o), 32'h3000);

        // Zero attack step jumps to peak; negative full-scale sample through the VCA.
        phase = "vca";
        attack_step_i = 16'h0000;
        cyc(); chk("att_zero", 32'(env_o), 32'hFFFF);
        env_tick_i = 1'b0; sample_i = 16'sh8000;
        cyc(); chk("vca_neg", sample_o, 32'hFFFF8000);

        // Reset in the middle of an attack.
        phase = "rst_mid";
        rst = 1'b1; cyc();
        rst = 1'b0; attack_step_i = 16'h0100; env_tick_i = 1'b1;
        cyc(); cyc();
        chk("pre_rst", 32'(env_o), 32'h0200);
        rst = 1'b1;
        cyc();
        chk("mid_env", 32'(env_o), 32'h0);
        chk("mid_active", 32'(active_o), 32'h0);
        chk("mid_sample", sample_o, 32'h0);
        rst = 1'b0; gate_i = 1'b0; sample_i = 16'h7FFF;
        cyc(); cyc();
        chk("vca_zero", sample_o, 32'h0);

`ifdef ADSR_VELOCITY_EN
        phase = "velocity";
        velocity_i = 7'd64; gate_i = 1'b1; attack_step_i = 16'h0000;
        cyc(); chk("vel_peak", 32'(env_o), 32'h81FF);
        gate_i = 1'b0;
        cyc();
`endif

        // Randomized traffic against the model.
        phase = "rand";
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 799) == 0);
            env_tick_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) gate_i = ~gate_i;
            sample_i = 16'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                attack_step_i  = pick_step();
                decay_step_i   = pick_step();
                release_step_i = pick_step();
                sustain_lvl_i  = 16'($urandom);
            end
`ifdef ADSR_VELOCITY_EN
            if ($urandom_range(0, 7) == 0) velocity_i = 7'($urandom);
`endif
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
